// File: rtl/maxpool_stream.sv
// Streaming POOLxPOOL max-pool (stride POOL) over a raster-scan feature map.
// Keeps one row of partial column maxima instead of a full window buffer.
module maxpool_stream #(
    parameter int unsigned DW     = 16,
    parameter int unsigned POOL   = 2,
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28,
    parameter int unsigned SIGNED = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last
);

    localparam int unsigned OW = IMG_W / POOL;
    localparam int unsigned OH = IMG_H / POOL;
    localparam int unsigned CW = $clog2(IMG_W + 1);
    localparam int unsigned RW = $clog2(IMG_H + 1);
    localparam int unsigned XW = (OW > 1) ? $clog2(OW) : 1;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [DW-1:0] acc;
    logic [DW-1:0] pbuf [OW];

    logic          accept_c;
    logic          in_range_c;
    logic          kx_first_c;
    logic          kx_last_c;
    logic          ky_first_c;
    logic          ky_last_c;
    logic          last_win_c;
    logic [XW-1:0] ox_c;
    logic [DW-1:0] hmax_c;
    logic [DW-1:0] vmax_c;

    function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic gt;
        if (SIGNED != 0) gt = $signed(a) > $signed(b);
        else             gt = a > b;
        return gt ? a : b;
    endfunction

    assign in_ready = !out_valid || out_ready;

    // Window position of the current pixel and the running maxima it produces
    always_comb begin
        accept_c   = in_valid && in_ready && !frame_clr;
        in_range_c = (col < CW'(OW * POOL)) && (row < RW'(OH * POOL));
        ox_c       = XW'(col / CW'(POOL));
        kx_first_c = (col % CW'(POOL)) == '0;
        kx_last_c  = (col % CW'(POOL)) == CW'(POOL - 1);
        ky_first_c = (row % RW'(POOL)) == '0;
        ky_last_c  = (row % RW'(POOL)) == RW'(POOL - 1);
        last_win_c = (ox_c == XW'(OW - 1)) && ((row / RW'(POOL)) == RW'(OH - 1));
        hmax_c     = kx_first_c ? in_data : max2(acc, in_data);
        vmax_c     = ky_first_c ? hmax_c : max2(pbuf[ox_c], hmax_c);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || frame_clr) begin
            col       <= '0;
            row       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (accept_c) begin
                if (col == CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                if (in_range_c) begin
                    acc <= hmax_c;
                    // A completed window overrides the clear above, so no bubble appears
                    if (kx_last_c && ky_last_c) begin
                        out_data  <= vmax_c;
                        out_valid <= 1'b1;
                        out_last  <= last_win_c;
                    end
                end
            end
        end
    end

    // Partial column maxima; contents never need clearing since ky==0 overwrites
    always_ff @(posedge clk) begin
        if (rst_n && accept_c && in_range_c && kx_last_c && !ky_last_c) begin
            pbuf[ox_c] <= vmax_c;
        end
    end

endmodule

// File: tb/tb_maxpool_stream.sv
// Bench for maxpool_stream: directed cases plus randomized frames against a window-max model.
module tb_maxpool_stream;

    localparam int unsigned NI = 6;

    function automatic int unsigned cfg_pool(input int k);
        case (k)
            4:       return 3;
            5:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int unsigned cfg_w(input int k);
        case (k)
            0:       return 4;
            1:       return 5;
            4:       return 8;
            5:       return 9;
            default: return 2;
        endcase
    endfunction

    function automatic int unsigned cfg_h(input int k);
        case (k)
            0:       return 4;
            1:       return 5;
            4:       return 7;
            5:       return 10;
            default: return 2;
        endcase
    endfunction

    function automatic int unsigned cfg_s(input int k);
        return (k == 2 || k == 4) ? 1 : 0;
    endfunction

    logic          clk;
    logic          rst_n;
    logic [NI-1:0] frame_clr;
    logic [NI-1:0] in_valid;
    logic [NI-1:0] in_ready;
    logic [NI-1:0] out_valid;
    logic [NI-1:0] out_ready;
    logic [NI-1:0] out_last;
    logic [15:0]   in_data  [NI];
    logic [15:0]   out_data [NI];

    int          n_checks;
    int          n_errors;
    int          rdy_mode;
    int          send_cycles;
    logic        hold_seen;
    logic [15:0] pix_q [$];
    logic [16:0] exp_q [$];
    logic [16:0] got_q [$];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        maxpool_stream #(
            .DW    (16),
            .POOL  (cfg_pool(g)),
            .IMG_W (cfg_w(g)),
            .IMG_H (cfg_h(g)),
            .SIGNED(cfg_s(g))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .frame_clr(frame_clr[g]),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_data  (in_data[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data (out_data[g]),
            .out_last (out_last[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream ready: 0 = always, 1 = random, other = drop instance 0 ready once it presents data
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: begin
                out_ready = '1;
                hold_seen = 1'b0;
            end
            1: begin
                out_ready = NI'($urandom);
                hold_seen = 1'b0;
            end
            default: begin
                hold_seen    = hold_seen | out_valid[0];
                out_ready    = '1;
                out_ready[0] = !hold_seen;
            end
        endcase
    end

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rst_n && out_valid[k] && out_ready[k]) got_q.push_back({out_last[k], out_data[k]});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill_ramp(input int n);
        pix_q.delete();
        for (int i = 0; i < n; i++) pix_q.push_back(16'(i));
    endtask

    task automatic send(input int k, input bit gaps);
        bit took;
        int waited;
        send_cycles = 0;
        for (int i = 0; i < pix_q.size(); i++) begin
            if (gaps) begin
                while ($urandom_range(3, 0) == 0) begin
                    @(posedge clk);
                    #1;
                    send_cycles++;
                end
            end
            in_valid[k] = 1'b1;
            in_data[k]  = pix_q[i];
            took   = 1'b0;
            waited = 0;
            while (!took) begin
                @(negedge clk);
                took = in_ready[k];
                @(posedge clk);
                #1;
                send_cycles++;
                waited++;
                if (!took && waited > 500) begin
                    check("in_ready_timeout", 0, 1);
                    took = 1'b1;
                end
            end
            in_valid[k] = 1'b0;
        end
    endtask

    // Reference: max over each full POOLxPOOL tile; leftover columns/rows never form a tile
    task automatic model_frames(input int k, input int nf);
        int unsigned p, w, h, ow, oh, base, idx;
        bit          s;
        logic [15:0] m, v;
        p  = cfg_pool(k);
        w  = cfg_w(k);
        h  = cfg_h(k);
        s  = cfg_s(k) != 0;
        ow = w / p;
        oh = h / p;
        for (int f = 0; f < nf; f++) begin
            base = f * w * h;
            for (int oy = 0; oy < oh; oy++) begin
                for (int ox = 0; ox < ow; ox++) begin
                    m = pix_q[base + oy * p * w + ox * p];
                    for (int dy = 0; dy < p; dy++) begin
                        for (int dx = 0; dx < p; dx++) begin
                            idx = base + (oy * p + dy) * w + ox * p + dx;
                            v   = pix_q[idx];
                            if (s ? ($signed(v) > $signed(m)) : (v > m)) m = v;
                        end
                    end
                    exp_q.push_back({(oy == oh - 1) && (ox == ow - 1), m});
                end
            end
        end
    endtask

    task automatic drain(input string name);
        int w;
        int n;
        w = 0;
        while (got_q.size() < exp_q.size() && w < 3000) begin
            @(posedge clk);
            w++;
        end
        repeat (6) @(posedge clk);
        #1;
        check({name, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_data%0d", name, i), 32'(got_q[i][15:0]), 32'(exp_q[i][15:0]));
            check($sformatf("%s_last%0d", name, i), 32'(got_q[i][16]), 32'(exp_q[i][16]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic push_exp4(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [15:0] d);
        exp_q.push_back({1'b0, a});
        exp_q.push_back({1'b0, b});
        exp_q.push_back({1'b0, c});
        exp_q.push_back({1'b1, d});
    endtask

    initial begin
        int w;
        n_checks  = 0;
        n_errors  = 0;
        rdy_mode  = 0;
        hold_seen = 1'b0;
        rst_n     = 1'b0;
        frame_clr = '0;
        in_valid  = '0;
        for (int k = 0; k < NI; k++) in_data[k] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_out_data0", 32'(out_data[0]), 0);
        check("rst_in_ready", 32'(in_ready), 32'((1 << NI) - 1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 4x4 ramp
        fill_ramp(16);
        send(0, 1'b0);
        push_exp4(5, 7, 13, 15);
        drain("t1");

        // Signed vs unsigned compare on 2x2 frames
        pix_q = '{16'hFFFD, 16'hFFFF, 16'hFFF8, 16'hFFFE};
        send(2, 1'b0);
        exp_q.push_back({1'b1, 16'hFFFF});
        drain("t2_neg_s");
        send(3, 1'b0);
        exp_q.push_back({1'b1, 16'hFFFF});
        drain("t2_neg_u");
        pix_q = '{16'hFFFF, 16'd5, 16'd3, 16'd2};
        send(2, 1'b0);
        exp_q.push_back({1'b1, 16'd5});
        drain("t2_mix_s");
        send(3, 1'b0);
        exp_q.push_back({1'b1, 16'hFFFF});
        drain("t2_mix_u");

        // Backpressure held from the first output
        fill_ramp(16);
        rdy_mode = 2;
        fork
            send(0, 1'b0);
            begin
                w = 0;
                @(negedge clk);
                while (!out_valid[0] && w < 200) begin
                    @(negedge clk);
                    w++;
                end
                check("t3_valid_seen", 32'(out_valid[0]), 1);
                for (int i = 0; i < 4; i++) begin
                    check($sformatf("t3_hold_data%0d", i), 32'(out_data[0]), 5);
                    check($sformatf("t3_hold_valid%0d", i), 32'(out_valid[0]), 1);
                    check($sformatf("t3_in_ready%0d", i), 32'(in_ready[0]), 0);
                    @(negedge clk);
                end
                rdy_mode = 0;
            end
        join
        push_exp4(5, 7, 13, 15);
        drain("t3");

        // 5x5 with trailing column and row discarded
        fill_ramp(25);
        send(1, 1'b0);
        push_exp4(6, 8, 16, 18);
        drain("t4");

        // Reset mid-frame then replay
        fill_ramp(6);
        send(0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t5_rst_valid", 32'(out_valid[0]), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        got_q.delete();
        fill_ramp(16);
        send(0, 1'b0);
        push_exp4(5, 7, 13, 15);
        drain("t5");

        // frame_clr mid-frame, with a competing pixel that must be dropped
        pix_q = '{16'd100, 16'd200, 16'd300};
        send(0, 1'b0);
        frame_clr[0] = 1'b1;
        in_valid[0]  = 1'b1;
        in_data[0]   = 16'hFFFF;
        @(posedge clk);
        #1;
        frame_clr[0] = 1'b0;
        in_valid[0]  = 1'b0;
        check("t5_clr_valid", 32'(out_valid[0]), 0);
        fill_ramp(16);
        send(0, 1'b0);
        push_exp4(5, 7, 13, 15);
        drain("t5_clr");

        // Two back-to-back frames without gaps
        fill_ramp(16);
        for (int i = 0; i < 16; i++) pix_q.push_back(16'(i));
        send(0, 1'b0);
        check("t6_cycles", send_cycles, 32);
        push_exp4(5, 7, 13, 15);
        push_exp4(5, 7, 13, 15);
        drain("t6");

        // Random frames with input gaps and random downstream stalls
        for (int r = 0; r < 3; r++) begin
            int k;
            k = (r == 0) ? 0 : r + 3;
            for (int rep = 0; rep < 2; rep++) begin
                rdy_mode = 1;
                pix_q.delete();
                for (int i = 0; i < 2 * cfg_w(k) * cfg_h(k); i++) pix_q.push_back(16'($urandom));
                send(k, 1'b1);
                model_frames(k, 2);
                drain($sformatf("rnd_k%0d_%0d", k, rep));
            end
        end
        rdy_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
